core_row_scheduler: RTL

CORE_ROW_SCHEDULER -- requirements
Module: core_row_scheduler

---
 rtl/sched_pkg.sv | 14 +
 rtl/core_pick_arb.sv | 24 ++
 rtl/core_row_scheduler.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/sched_pkg.sv
// Shared types and default sizing for the row scheduler.
package sched_pkg;

  localparam int DEF_CORES = 4;
  localparam int DEF_ROWS  = 8;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DISPATCH = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_DONE     = 2'd3
  } sched_state_e;

endpackage

// File: rtl/core_pick_arb.sv
// Fixed-priority picker: grants the lowest-indexed requesting core.
module core_pick_arb #(
  parameter int N = 4
) (
  input  logic [N-1:0] req_i,
  output logic [N-1:0] grant_o,
  output logic         valid_o
);

  // Walk from core 0 upward and stop at the first request.
  always_comb begin
    logic found;
    grant_o = '0;
    found   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (req_i[i] && !found) begin
        grant_o[i] = 1'b1;
        found      = 1'b1;
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/core_row_scheduler.sv
// Row scheduler: hands output rows of a job to idle cores one per cycle,
// counts completed rows and reports job end and protocol errors.
module core_row_scheduler
  import sched_pkg::*;
#(
  parameter int CORES = DEF_CORES,
  parameter int ROWS  = DEF_ROWS,
  parameter int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   status,
  input  logic [ROW_W:0]         rows_cfg,
  input  logic [CORES-1:0]       core_done,
  output logic [CORES-1:0]       core_start,
  output logic [CORES*ROW_W-1:0] core_row,
  output logic                   busy,
  output logic                   end_process,
  output logic [ROW_W:0]         rows_done,
  output logic                   err
);

  localparam int CNT_W = ROW_W + 1;
  localparam int SUM_W = CNT_W + 5;
  localparam logic [CNT_W-1:0] ROWS_MAX = CNT_W'(ROWS);

  // Requests beyond the row capacity are treated as a full-size job.
  function automatic logic [CNT_W-1:0] clamp_rows(input logic [CNT_W-1:0] req);
    return (req > ROWS_MAX) ? ROWS_MAX : req;
  endfunction

  // Number of cores reporting completion this cycle.
  function automatic logic [SUM_W-1:0] popcount(input logic [CORES-1:0] v);
    logic [SUM_W-1:0] c;
    c = '0;
    for (int i = 0; i < CORES; i++) begin
      c = c + SUM_W'(v[i]);
    end
    return c;
  endfunction

  sched_state_e           state_q, state_d;
  logic [CNT_W-1:0]       cfg_q, cfg_d;
  logic [CNT_W-1:0]       next_row_q, next_row_d;
  logic [CNT_W-1:0]       rows_done_q, rows_done_d;
  logic                   err_q, err_d;
  logic [CORES-1:0]       active_q, active_d;
  logic [CORES-1:0]       core_start_q, core_start_d;
  logic [CORES*ROW_W-1:0] core_row_q, core_row_d;

  logic [CORES-1:0]       grant;
  logic                   grant_vld;
  logic [CORES-1:0]       credit;
  logic [CORES-1:0]       stray;
  logic [SUM_W-1:0]       done_sum;
  logic [CNT_W-1:0]       start_cfg;

  // A core that finishes this cycle still reads as active to the picker,
  // so it can only be handed a new row on the following cycle.
  core_pick_arb #(
    .N (CORES)
  ) u_pick (
    .req_i   (~active_q),
    .grant_o (grant),
    .valid_o (grant_vld)
  );

  assign credit    = core_done & active_q;
  assign stray     = core_done & ~active_q;
  assign start_cfg = clamp_rows(rows_cfg);

  // Next-state, issue and completion accounting.
  always_comb begin
    state_d      = state_q;
    cfg_d        = cfg_q;
    next_row_d   = next_row_q;
    rows_done_d  = rows_done_q;
    err_d        = err_q;
    active_d     = active_q;
    core_start_d = '0;
    core_row_d   = core_row_q;
    done_sum     = '0;

    if (state_q == ST_DISPATCH || state_q == ST_DRAIN) begin
      done_sum = SUM_W'(rows_done_q) + popcount(credit);
      if (done_sum > SUM_W'(cfg_q)) begin
        rows_done_d = cfg_q;
        err_d       = 1'b1;
      end else begin
        rows_done_d = done_sum[CNT_W-1:0];
      end
      if (|stray) begin
        err_d = 1'b1;
      end
      active_d = active_q & ~credit;
    end

    case (state_q)
      ST_IDLE: begin
        if (status) begin
          cfg_d       = start_cfg;
          next_row_d  = '0;
          rows_done_d = '0;
          err_d       = 1'b0;
          active_d    = '0;
          if (start_cfg == '0) begin
            state_d = ST_DONE;
          end else begin
            // Every core is idle at job start, so row 0 goes to core 0.
            core_start_d         = CORES'(1);
            active_d             = CORES'(1);
            core_row_d[0+:ROW_W] = '0;
            next_row_d           = CNT_W'(1);
            state_d              = (start_cfg == CNT_W'(1)) ? ST_DRAIN : ST_DISPATCH;
          end
        end else if (|core_done) begin
          err_d = 1'b1;
        end
      end
      ST_DISPATCH: begin
        if (grant_vld) begin
          core_start_d = grant;
          active_d     = active_d | grant;
          for (int i = 0; i < CORES; i++) begin
            if (grant[i]) begin
              core_row_d[i*ROW_W+:ROW_W] = next_row_q[ROW_W-1:0];
            end
          end
          next_row_d = next_row_q + CNT_W'(1);
          if (next_row_q == cfg_q - CNT_W'(1)) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (rows_done_d == cfg_q) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (|core_done) begin
          err_d = 1'b1;
        end
        if (!status) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset forces an idle, all-zero view.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cfg_q        <= '0;
      next_row_q   <= '0;
      rows_done_q  <= '0;
      err_q        <= 1'b0;
      active_q     <= '0;
      core_start_q <= '0;
      core_row_q   <= '0;
    end else begin
      state_q      <= state_d;
      cfg_q        <= cfg_d;
      next_row_q   <= next_row_d;
      rows_done_q  <= rows_done_d;
      err_q        <= err_d;
      active_q     <= active_d;
      core_start_q <= core_start_d;
      core_row_q   <= core_row_d;
    end
  end

  assign core_start  = core_start_q;
  assign core_row    = core_row_q;
  assign busy        = (state_q == ST_DISPATCH) || (state_q == ST_DRAIN);
  assign end_process = (state_q == ST_DONE);
  assign rows_done   = rows_done_q;
  assign err         = err_q;

endmodule
